// File: rtl/avmm_burst_mem_responder.sv
// Avalon-MM burst slave memory model for the kernel global-memory port; optional LFSR backpressure via AVMM_RESP_BACKPRESSURE_EN.
// Latency: writeack 1 cycle after the last write beat; first readdatavalid RD_LATENCY cycles after read acceptance, beats back-to-back.
// Backpressure: waitrequest held high through a read burst until the cycle after its last beat (plus LFSR stalls when the macro is set).
module avmm_burst_mem_responder #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 32,
  parameter int BURST_W    = 5,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     address,
  input  logic [BURST_W-1:0]    burstcount,
  input  logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W/8-1:0]   byteenable,
  output logic                  waitrequest,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  writeack,
  output logic                  protocol_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t                 state;
  logic [DATA_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  addr_idx, wr_idx, rd_idx, mem_widx;
  logic [BURST_W-1:0]     eff_bc, wr_left, rd_left, ret_left;
  logic                   wreq_q, wr_first, rd_first, wr_beat, mem_we, rd_issue;
  logic [DATA_W-1:0]      pipe_dat [RD_LATENCY];
  logic [RD_LATENCY-1:0]  pipe_vld;
  logic                   addr_unused;

  // Only the word-index bits of the byte address select a location.
  assign addr_idx    = address[OFF +: DEPTH_LOG2];
  assign addr_unused = ^address;
  // A zero burstcount is served as a single beat (and flagged).
  assign eff_bc      = (burstcount == '0) ? BURST_W'(1) : burstcount;

`ifdef AVMM_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Free-running Fibonacci LFSR (taps 16,14,13,11) that injects random stalls.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Stalls never touch an accepted read; they only gate command/write acceptance.
  assign waitrequest = wreq_q | ((state != RD_BURST) && (lfsr[1:0] == 2'b00));
`else
  assign waitrequest = wreq_q;
`endif

  // Write wins over a simultaneous read in IDLE.
  assign wr_first = (state == IDLE) && write && !waitrequest;
  assign rd_first = (state == IDLE) && read && !write && !waitrequest;
  assign wr_beat  = (state == WR_BURST) && write && !waitrequest;
  assign mem_we   = wr_first || wr_beat;
  assign mem_widx = wr_first ? addr_idx : wr_idx;
  assign rd_issue = (state == RD_BURST) && (rd_left != '0);

  // Byte-masked memory write; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (byteenable[b]) mem[mem_widx][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
  end

  // Burst sequencing FSM: command acceptance, write counting, read issue/return tracking, error flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      wreq_q       <= 1'b1;
      writeack     <= 1'b0;
      protocol_err <= 1'b0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      wr_left      <= '0;
      rd_left      <= '0;
      ret_left     <= '0;
    end else begin
      writeack <= 1'b0;
      if ((state == IDLE) && (read || write) && !waitrequest && (burstcount == '0)) protocol_err <= 1'b1;
      if ((state == IDLE) && read && write && !waitrequest) protocol_err <= 1'b1;
      if ((state == WR_BURST) && read) protocol_err <= 1'b1;
      case (state)
        IDLE: begin
          wreq_q <= 1'b0;
          if (wr_first) begin
            wr_idx  <= addr_idx + 1'b1;
            wr_left <= eff_bc - 1'b1;
            if (eff_bc == BURST_W'(1)) writeack <= 1'b1;
            else                       state    <= WR_BURST;
          end else if (rd_first) begin
            rd_idx   <= addr_idx;
            rd_left  <= eff_bc;
            ret_left <= eff_bc;
            wreq_q   <= 1'b1;
            state    <= RD_BURST;
          end
        end
        WR_BURST: begin
          if (wr_beat) begin
            wr_idx  <= wr_idx + 1'b1;
            wr_left <= wr_left - 1'b1;
            if (wr_left == BURST_W'(1)) begin
              writeack <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        RD_BURST: begin
          if (rd_issue) begin
            rd_idx  <= rd_idx + 1'b1;
            rd_left <= rd_left - 1'b1;
          end
          if (readdatavalid) begin
            ret_left <= ret_left - 1'b1;
            if (ret_left == BURST_W'(1)) begin
              wreq_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Fixed-latency read return pipeline; reset discards in-flight beats.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_dat[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_issue;
      pipe_dat[0] <= mem[rd_idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign readdata      = pipe_dat[RD_LATENCY-1];
  assign readdatavalid = pipe_vld[RD_LATENCY-1];

endmodule

// File: tb/tb_avmm_burst_mem_responder.sv
// Randomized bench for avmm_burst_mem_responder against a word-array memory model.
// Checks writeack timing, read latency/contiguity, waitrequest release, error flag and reset abort.
// Inputs driven on the falling edge, outputs observed on the falling edge after each active edge.
module tb_avmm_burst_mem_responder;

  localparam int DW  = 256;
  localparam int AW  = 32;
  localparam int BW  = 5;
  localparam int DL  = 10;
  localparam int LAT = 2;
  localparam int NB  = DW / 8;
  localparam int DEPTH = 1 << DL;

  logic           clock = 1'b0;
  logic           resetn;
  logic           read, write;
  logic [AW-1:0]  address;
  logic [BW-1:0]  burstcount;
  logic [DW-1:0]  writedata;
  logic [NB-1:0]  byteenable;
  logic           waitrequest;
  logic [DW-1:0]  readdata;
  logic           readdatavalid;
  logic           writeack;
  logic           protocol_err;

  avmm_burst_mem_responder #(
    .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .DEPTH_LOG2(DL), .RD_LATENCY(LAT)
  ) dut (
    .clock(clock), .resetn(resetn), .read(read), .write(write), .address(address),
    .burstcount(burstcount), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .writeack(writeack), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wd  [16];
  logic [NB-1:0] wbe [16];
  int            gap [16];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          err_exp = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < NB; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (waitrequest && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) chk({tag, "_timeout"}, waitrequest, 0);
  endtask

  // Writes n beats from wd/wbe with gap[] idle cycles before each beat.
  task automatic wr_burst(input int idx, input int n, input logic [BW-1:0] bc_field);
    for (int b = 0; b < n; b++) begin
      for (int g = 0; g < gap[b]; g++) begin
        write = 1'b0;
        @(negedge clock);
      end
      write      = 1'b1;
      address    = (b == 0) ? AW'(idx << 5) : AW'($urandom);
      burstcount = (b == 0) ? bc_field : BW'($urandom);
      writedata  = wd[b];
      byteenable = wbe[b];
      wait_ready("wr_ready");
      @(negedge clock);
      write = 1'b0;
      model[(idx + b) % DEPTH] = merge(model[(idx + b) % DEPTH], wd[b], wbe[b]);
      chk("writeack", writeack, (b == n - 1) ? 1 : 0);
    end
    @(negedge clock);
    chk("writeack_end", writeack, 0);
  endtask

  task automatic rd_burst(input int idx, input int n);
    read       = 1'b1;
    address    = AW'(idx << 5);
    burstcount = BW'(n);
    wait_ready("rd_ready");
    @(negedge clock);
    read    = 1'b0;
    address = AW'($urandom);
    chk("rd_lat_vld", readdatavalid, 0);
    chk("rd_busy", waitrequest, 1);
    for (int k = 1; k < LAT; k++) begin
      @(negedge clock);
      chk("rd_lat_vld", readdatavalid, 0);
    end
    for (int b = 0; b < n; b++) begin
      @(negedge clock);
      chk("rd_vld", readdatavalid, 1);
      chk("rd_data", readdata, model[(idx + b) % DEPTH]);
      chk("rd_busy", waitrequest, 1);
    end
    @(negedge clock);
    chk("rd_vld_end", readdatavalid, 0);
    chk("rd_release", waitrequest, 0);
  endtask

  task automatic set_beats(input int n, input bit full_be, input int max_gap);
    for (int b = 0; b < 16; b++) begin
      wd[b]  = rnd_word();
      wbe[b] = full_be ? {NB{1'b1}} : NB'({$urandom, $urandom});
      gap[b] = (b < n && max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, n;
    resetn = 1'b0; read = 1'b0; write = 1'b0; address = '0; burstcount = '0;
    writedata = '0; byteenable = '0;
    repeat (3) @(negedge clock);
    chk("rst_waitreq", waitrequest, 1);
    chk("rst_rdv", readdatavalid, 0);
    chk("rst_rdata", readdata, 0);
    chk("rst_wack", writeack, 0);
    chk("rst_perr", protocol_err, 0);
    resetn = 1'b1;
    @(negedge clock);
    chk("rst_release", waitrequest, 0);

    // Fill the whole memory so every later read has a defined reference.
    for (int blk = 0; blk < DEPTH / 16; blk++) begin
      set_beats(16, 1'b1, 0);
      wr_burst(blk * 16, 16, BW'(16));
    end

    // Single write of A5 bytes at 0x40, read back.
    set_beats(1, 1'b1, 0);
    wd[0] = {NB{8'hA5}};
    wr_burst(32'h40 >> 5, 1, BW'(1));
    rd_burst(32'h40 >> 5, 1);
    chk("a5_model", model[2], {NB{8'hA5}});

    // Burst of 4 with a 2-cycle gap before the third beat, then read 16.
    set_beats(4, 1'b1, 0);
    for (int b = 0; b < 4; b++) wd[b] = DW'(b + 1);
    gap[2] = 2;
    wr_burst(0, 4, BW'(4));
    rd_burst(0, 16);

    // Partial byteenable over an all-ones word.
    set_beats(1, 1'b1, 0);
    wd[0] = {DW{1'b1}};
    wr_burst(5, 1, BW'(1));
    wd[0] = '0;
    wbe[0] = NB'(32'h0000000F);
    wr_burst(5, 1, BW'(1));
    chk("partial_model", model[5], {{(DW-32){1'b1}}, 32'h0});
    rd_burst(5, 1);

    // Burst of 2 from the last word wraps to index 0.
    set_beats(2, 1'b1, 0);
    wr_burst(DEPTH - 1, 2, BW'(2));
    rd_burst(0, 1);
    rd_burst(DEPTH - 1, 2);

    // Randomized mix of write and read bursts.
    for (int op = 0; op < 40; op++) begin
      idx = int'($urandom_range(DEPTH - 1, 0));
      n   = int'($urandom_range(16, 1));
      if ($urandom_range(1, 0) == 1) begin
        set_beats(n, 1'b0, 2);
        wr_burst(idx, n, BW'(n));
      end else begin
        rd_burst(idx, n);
      end
      if ($urandom_range(1, 0) == 1) rd_burst(idx, n);
    end
    chk("perr_clean", protocol_err, 0);

    // Read and write together in IDLE: write wins, error sticks.
    idx = 77;
    writedata  = rnd_word();
    read = 1'b1; write = 1'b1;
    address = AW'(idx << 5); burstcount = BW'(1); byteenable = {NB{1'b1}};
    wait_ready("rw_ready");
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    model[idx] = writedata;
    err_exp = 1'b1;
    chk("rw_wack", writeack, 1);
    chk("rw_perr", protocol_err, err_exp);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("rw_no_rdv", readdatavalid, 0);
      chk("rw_ready_after", waitrequest, 0);
    end
    rd_burst(idx, 1);
    chk("perr_sticky", protocol_err, err_exp);

    // burstcount 0 behaves as a single beat.
    set_beats(1, 1'b1, 0);
    wr_burst(300, 1, BW'(0));
    rd_burst(300, 2);
    chk("perr_bc0", protocol_err, err_exp);

    // Reset during the third beat of a 16-beat read.
    read = 1'b1; address = '0; burstcount = BW'(16);
    wait_ready("rst_rd_ready");
    @(negedge clock);
    read = 1'b0;
    repeat (LAT + 2) @(negedge clock);
    chk("mid_rdv", readdatavalid, 1);
    chk("mid_data", readdata, model[2]);
    #2 resetn = 1'b0;
    #1;
    err_exp = 1'b0;
    chk("abort_rdv", readdatavalid, 0);
    chk("abort_waitreq", waitrequest, 1);
    chk("abort_perr", protocol_err, err_exp);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("abort_release", waitrequest, 0);
    chk("abort_no_rdv", readdatavalid, 0);
    rd_burst(0, 4);
    rd_burst(DEPTH - 1, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avmm_burst_mem_responder.md
Name: avmm_burst_mem_responder

Overview:
- Avalon-MM burst slave memory model: the responder end of the kernel global-memory master port (`avm_memgmem0_port_0_0_rw_*`).
- Replaces the onchip RAM system in kernel simulation.
- Accepts pipelined burst writes and reads; returns read data with fixed latency.
- Emits writeack and a sticky protocol-error flag for bench checking.

Parameters:
- DATA_W, 256, data width in bits; multiple of 8.
- ADDR_W, 32, byte address width.
- BURST_W, 5, burstcount width; max burst is 2^(BURST_W-1) = 16.
- DEPTH_LOG2, 10, log2 of memory words.
- RD_LATENCY, 2, cycles from read command acceptance to first readdatavalid; range 1..8.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- read  in  1  read command.
- write  in  1  write beat.
- address  in  ADDR_W  byte address; word-aligned to DATA_W/8.
- burstcount  in  BURST_W  beats in burst; sampled on first beat only.
- writedata  in  DATA_W  write data.
- byteenable  in  DATA_W/8  per-byte write enable.
- waitrequest  out  1  command/beat not accepted this cycle.
- readdata  out  DATA_W  read data.
- readdatavalid  out  1  readdata valid.
- writeack  out  1  one-cycle pulse per completed write burst.
- protocol_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values (async on resetn=0): waitrequest=1, readdatavalid=0, readdata=0, writeack=0, protocol_err=0, state=IDLE, counters 0. Memory contents are not reset. waitrequest goes to 0 on the first clock after resetn deasserts.
- Word index = (address >> log2(DATA_W/8)) mod 2^DEPTH_LOG2. Burst beats increment the index by 1 and wrap modulo depth.
- Accept rule: a beat or command is accepted on a rising edge where (read|write)=1 and waitrequest=0.
- FSM states: IDLE, WR_BURST, RD_BURST.
- IDLE, write accepted:
  - write beat 0 with byteenable; latch index+1 and remaining = burstcount-1.
  - If burstcount==1: pulse writeack next cycle, stay IDLE; else go to WR_BURST.
- IDLE, read accepted:
  - latch index and count = burstcount; go to RD_BURST.
  - waitrequest=1 from the next cycle until the cycle after the last readdatavalid.
- IDLE, read and write asserted together: write wins, read ignored, protocol_err set.
- burstcount==0 on the first beat: treated as 1, protocol_err set.
- WR_BURST:
  - waitrequest=0; each accepted write beat stores at the current index; remaining decrements.
  - Address and burstcount are ignored.
  - read asserted in WR_BURST: protocol_err set, read ignored.
  - Last beat accepted: writeack=1 on the next cycle, then back to IDLE.
  - write low cycles within a burst are allowed (beats stall).
- RD_BURST:
  - Memory read issued one word per cycle.
  - First readdatavalid exactly RD_LATENCY cycles after the acceptance edge; beats then returned on consecutive cycles, never gapped.
  - Last beat returned: back to IDLE; waitrequest=0 the following cycle.
- Read-after-write to the same word in the next cycle returns the new data (write-first).
- Reset mid-burst: burst aborted, in-flight read data discarded, no writeack, writes already committed remain.

Optional Feature:
- Macro AVMM_RESP_BACKPRESSURE_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) forces waitrequest=1 in IDLE and WR_BURST whenever lfsr[1:0]==2'b00.
  - The LFSR advances every cycle out of reset.
  - Read return timing is unaffected once a read is accepted.
- Undefined: no LFSR; waitrequest follows only the FSM rules above.

Test Plan:
- Single write 0xA5 repeated across all bytes to address 0x40, byteenable all-ones, then read burstcount=1 at 0x40 -> writeack 1 cycle after the write; readdatavalid exactly 2 cycles after read acceptance with data 0xA5…A5.
- Write burst of 4 from 0x0 with data 1,2,3,4 (write gaps of 2 cycles between beats 2 and 3), then read burst 16 from 0x0 -> single writeack after beat 4; 16 contiguous readdatavalid beats, first 4 = 1,2,3,4.
- Partial byteenable 0x0000000F over word 0xFF…FF with data 0 -> readback low 4 bytes 0, rest 0xFF.
- Burst of 2 starting at the last word (index 1023, address 0x7FE0) -> second beat lands at index 0; readback at 0x0 matches.
- read and write high together in IDLE -> write performed, no readdatavalid, protocol_err=1 and remains 1 until reset.
- resetn pulsed low during 3rd beat of a 16-beat read -> readdatavalid=0 immediately, waitrequest=1, protocol_err=0; a subsequent read works normally with latency 2.
